// File: rtl/usb_personality_pkg.sv
// rtl/usb_personality_pkg.sv - shared personality codes, error codes and ctrl FSM encoding
package usb_personality_pkg;

    localparam int NUM_PERSONALITIES = 5;

    localparam logic [2:0] PERS_GREASEWEAZLE = 3'd0;
    localparam logic [2:0] PERS_KRYOFLUX     = 3'd1;
    localparam logic [2:0] PERS_FLUXENGINE   = 3'd2;
    localparam logic [2:0] PERS_MSC          = 3'd3;
    localparam logic [2:0] PERS_MSC_RAW      = 3'd4;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_REQUEST    = 3'd2,
        ST_WAIT_ACK   = 3'd3,
        ST_DISCONNECT = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/usb_personality_ctrl.sv
// rtl/usb_personality_ctrl.sv - personality-switch initiator with ack timeout, retry and soft-disconnect hold
module usb_personality_ctrl #(
    parameter int NUM_PERSONALITIES   = usb_personality_pkg::NUM_PERSONALITIES,
    parameter int DEFAULT_PERSONALITY = 4,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int MAX_RETRIES         = 2,
    parameter int DISCONNECT_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_sel,
    output logic       cmd_ready,
    output logic [2:0] personality_sel,
    output logic       personality_switch,
    input  logic       switch_complete,
    input  logic [2:0] active_personality,
    input  logic       personality_valid,
    output logic       usb_disconnect,
    output logic       done,
    output logic       busy,
    output logic [1:0] last_error,
    output logic [7:0] switch_count,
    output logic [2:0] ctrl_state
);
    import usb_personality_pkg::*;

    localparam logic [3:0]  NUM_PERS     = 4'(NUM_PERSONALITIES);
    localparam logic [2:0]  DEFAULT_SEL  = 3'(DEFAULT_PERSONALITY);
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] DISC_LOAD    = 16'(DISCONNECT_CYCLES - 1);
    localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRIES);

    ctrl_state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  retries, retries_n;
    logic [2:0]  target, target_n;
    logic [2:0]  sel_q, sel_n;
    logic [1:0]  err_q, err_n;
    logic [7:0]  count_q, count_n;
    logic        via_disc, via_disc_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            retries  <= '0;
            target   <= '0;
            sel_q    <= DEFAULT_SEL;
            err_q    <= ERR_NONE;
            count_q  <= '0;
            via_disc <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            retries  <= retries_n;
            target   <= target_n;
            sel_q    <= sel_n;
            err_q    <= err_n;
            count_q  <= count_n;
            via_disc <= via_disc_n;
        end
    end

    always_comb begin
        state_n            = state;
        cnt_n              = cnt;
        retries_n          = retries;
        target_n           = target;
        sel_n              = sel_q;
        err_n              = err_q;
        count_n            = count_q;
        via_disc_n         = via_disc;
        cmd_ready          = 1'b0;
        personality_switch = 1'b0;
        usb_disconnect     = 1'b0;
        done               = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = personality_valid;
                if (cmd_valid && personality_valid) begin
                    target_n   = cmd_sel;
                    err_n      = ERR_NONE;
                    retries_n  = '0;
                    via_disc_n = 1'b0;
                    state_n    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ({1'b0, target} >= NUM_PERS) begin
                    err_n   = ERR_RANGE;
                    state_n = ST_ERROR;
                end else if (target == active_personality) begin
                    state_n = ST_DONE;
                end else begin
                    // Load the select ahead of the pulse so the mux samples a settled code.
                    sel_n   = target;
                    state_n = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                personality_switch = 1'b1;
                sel_n              = target;
                cnt_n              = TIMEOUT_LOAD;
                state_n            = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An ack landing on the expiry cycle still counts as success.
                if (switch_complete) begin
                    if (active_personality == target) begin
                        cnt_n      = DISC_LOAD;
                        via_disc_n = 1'b1;
                        state_n    = ST_DISCONNECT;
                    end else begin
                        err_n   = ERR_MISMATCH;
                        state_n = ST_ERROR;
                    end
                end else if (cnt == '0) begin
                    if (retries < RETRY_MAX) begin
                        retries_n = retries + 3'd1;
                        state_n   = ST_REQUEST;
                    end else begin
                        err_n   = ERR_TIMEOUT;
                        state_n = ST_ERROR;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_DISCONNECT: begin
                usb_disconnect = 1'b1;
                if (cnt == '0) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (via_disc && (count_q != 8'hFF)) begin
                    count_n = count_q + 8'd1;
                end
                state_n = ST_IDLE;
            end
            ST_ERROR: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy            = (state != ST_IDLE);
    assign ctrl_state      = state;
    assign personality_sel = sel_q;
    assign last_error      = err_q;
    assign switch_count    = count_q;

endmodule

// File: tb/tb_usb_personality_ctrl.sv
// tb/tb_usb_personality_ctrl.sv - scoreboard bench for usb_personality_ctrl with a reactive mux model
module tb_usb_personality_ctrl;
    import usb_personality_pkg::*;

    localparam int T = 16;
    localparam int D = 20;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_sel;
    logic       cmd_ready;
    logic [2:0] personality_sel;
    logic       personality_switch;
    logic       switch_complete;
    logic [2:0] active_personality;
    logic       personality_valid;
    logic       usb_disconnect;
    logic       done;
    logic       busy;
    logic [1:0] last_error;
    logic [7:0] switch_count;
    logic [2:0] ctrl_state;

    always #5 clk = ~clk;

    usb_personality_ctrl #(
        .NUM_PERSONALITIES  (5),
        .DEFAULT_PERSONALITY(4),
        .TIMEOUT_CYCLES     (T),
        .MAX_RETRIES        (R),
        .DISCONNECT_CYCLES  (D)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_sel           (cmd_sel),
        .cmd_ready         (cmd_ready),
        .personality_sel   (personality_sel),
        .personality_switch(personality_switch),
        .switch_complete   (switch_complete),
        .active_personality(active_personality),
        .personality_valid (personality_valid),
        .usb_disconnect    (usb_disconnect),
        .done              (done),
        .busy              (busy),
        .last_error        (last_error),
        .switch_count      (switch_count),
        .ctrl_state        (ctrl_state)
    );

    typedef struct {
        int err;
        int cnt;
        int pulses;
        int disc;
        int done_idx;
        int sel;
        int spacing;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int         mux_delay      = 6;
    logic       mux_ack_en     = 1'b1;
    logic [2:0] mux_ack_active = 3'd0;
    logic       mux_preset_req = 1'b0;
    logic [2:0] mux_preset_val = 3'd0;

    // Mux model: acks mux_delay cycles after a sampled switch pulse.
    initial begin
        int pend;
        pend               = 0;
        switch_complete    = 1'b0;
        active_personality = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            switch_complete = 1'b0;
            if (mux_preset_req) begin
                active_personality = mux_preset_val;
                pend               = 0;
            end
            if (personality_switch && mux_ack_en) begin
                pend = mux_delay;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    switch_complete    = 1'b1;
                    active_personality = mux_ack_active;
                end
            end
        end
    end

    task automatic preset_active(input logic [2:0] v);
        @(negedge clk);
        mux_preset_val = v;
        mux_preset_req = 1'b1;
        @(negedge clk);
        mux_preset_req = 1'b0;
    endtask

    task automatic issue(input logic [2:0] sel);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        exp_t e;
        int   idx, pulses, disc, first_sel, done_idx;
        int   pidx[$];
        idx = 1; pulses = 0; disc = 0; first_sel = -1; done_idx = -1;
        while (idx <= budget) begin
            if (personality_switch) begin
                if (pulses == 0) first_sel = int'(personality_sel);
                pidx.push_back(idx);
                pulses++;
            end
            if (usb_disconnect) disc++;
            if (done) begin
                done_idx = idx;
                break;
            end
            @(negedge clk);
            idx++;
        end
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (done_idx != e.done_idx) begin
            bad++;
            $display("FAIL %s done_idx: got %0d required %0d", name, done_idx, e.done_idx);
        end
        total++;
        if (int'(last_error) != e.err) begin
            bad++;
            $display("FAIL %s last_error: got %0d required %0d", name, last_error, e.err);
        end
        total++;
        if (int'(switch_count) != e.cnt) begin
            bad++;
            $display("FAIL %s switch_count: got %0d required %0d", name, switch_count, e.cnt);
        end
        total++;
        if (pulses != e.pulses) begin
            bad++;
            $display("FAIL %s pulses: got %0d required %0d", name, pulses, e.pulses);
        end
        total++;
        if (disc != e.disc) begin
            bad++;
            $display("FAIL %s disconnect_cycles: got %0d required %0d", name, disc, e.disc);
        end
        if (e.sel >= 0) begin
            total++;
            if (first_sel != e.sel) begin
                bad++;
                $display("FAIL %s sel_at_pulse: got %0d required %0d", name, first_sel, e.sel);
            end
        end
        if (e.spacing > 0) begin
            for (int i = 1; i < pidx.size(); i++) begin
                total++;
                if (pidx[i] - pidx[i-1] != e.spacing) begin
                    bad++;
                    $display("FAIL %s pulse_spacing: got %0d required %0d", name, pidx[i] - pidx[i-1], e.spacing);
                end
            end
            if (pidx.size() > 0) begin
                total++;
                if (pidx[0] != 2) begin
                    bad++;
                    $display("FAIL %s first_pulse_idx: got %0d required 2", name, pidx[0]);
                end
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after_done: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        cmd_valid         = 1'b0;
        cmd_sel           = 3'd0;
        personality_valid = 1'b1;
        preset_active(3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (personality_sel !== 3'd4) begin bad++; $display("FAIL reset_sel: got %0d required 4", personality_sel); end
        total++;
        if ({personality_switch, usb_disconnect, done, busy} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 0000", {personality_switch, usb_disconnect, done, busy});
        end
        total++;
        if (last_error !== 2'd0 || switch_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_status: err=%0d cnt=%0d required 0 0", last_error, switch_count);
        end
        total++;
        if (ctrl_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d required 0", ctrl_state); end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_valid: got %b required 1", cmd_ready); end
        personality_valid = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_invalid: got %b required 0", cmd_ready); end
        personality_valid = 1'b1;
    endtask

    task automatic test_switch();
        mux_delay = 6; mux_ack_active = 3'd1; mux_ack_en = 1'b1;
        sb.push_back('{err: 0, cnt: 1, pulses: 1, disc: D, done_idx: 3 + 6 + D, sel: 1, spacing: 0});
        issue(3'd1);
        wait_done("switch", 200);
    endtask

    task automatic test_noop();
        preset_active(3'd4);
        sb.push_back('{err: 0, cnt: 1, pulses: 0, disc: 0, done_idx: 2, sel: -1, spacing: 0});
        issue(3'd4);
        wait_done("noop", 50);
    endtask

    task automatic test_range();
        sb.push_back('{err: 1, cnt: 1, pulses: 0, disc: 0, done_idx: 2, sel: -1, spacing: 0});
        issue(3'd6);
        wait_done("range", 50);
    endtask

    task automatic test_retry();
        mux_ack_en = 1'b0;
        sb.push_back('{err: 2, cnt: 1, pulses: 3, disc: 0, done_idx: 2 + 3 * (T + 1), sel: 0, spacing: T + 1});
        issue(3'd0);
        wait_done("retry", 200);
        mux_ack_en = 1'b1;
    endtask

    task automatic test_mismatch();
        mux_delay = 6; mux_ack_active = 3'd3;
        sb.push_back('{err: 3, cnt: 1, pulses: 1, disc: 0, done_idx: 9, sel: 2, spacing: 0});
        issue(3'd2);
        wait_done("mismatch", 100);
    endtask

    task automatic test_expiry_ack();
        mux_delay = T; mux_ack_active = 3'd1;
        sb.push_back('{err: 0, cnt: 2, pulses: 1, disc: D, done_idx: 3 + T + D, sel: 1, spacing: 0});
        issue(3'd1);
        wait_done("expiry_ack", 200);
    endtask

    task automatic test_disconnect_reset();
        int   disc;
        logic ready_busy;
        logic sel_ok;
        mux_delay = 6; mux_ack_active = 3'd0;
        disc = 0; ready_busy = 1'b0; sel_ok = 1'b1;
        issue(3'd0);
        cmd_valid = 1'b1;
        cmd_sel   = 3'd2;
        for (int i = 0; i < 100 && disc < 10; i++) begin
            if (busy && cmd_ready) ready_busy = 1'b1;
            if (usb_disconnect) begin
                disc++;
                if (personality_sel !== 3'd0) sel_ok = 1'b0;
            end
            if (disc < 10) @(negedge clk);
        end
        total++;
        if (disc != 10) begin bad++; $display("FAIL dr_reach_disc: got %0d required 10", disc); end
        total++;
        if (ready_busy !== 1'b0) begin bad++; $display("FAIL dr_ready_busy: got %b required 0", ready_busy); end
        total++;
        if (sel_ok !== 1'b1) begin bad++; $display("FAIL dr_sel_before: got %b required 1", sel_ok); end
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (usb_disconnect !== 1'b0) begin bad++; $display("FAIL dr_disc_drop: got %b required 0", usb_disconnect); end
        total++;
        if (ctrl_state !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dr_state: got %0d busy=%b required 0 0", ctrl_state, busy);
        end
        total++;
        if (personality_sel !== 3'd4) begin bad++; $display("FAIL dr_sel: got %0d required 4", personality_sel); end
        total++;
        if (switch_count !== 8'd0) begin bad++; $display("FAIL dr_count: got %0d required 0", switch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_after_reset();
        mux_delay = 6; mux_ack_active = 3'd3;
        sb.push_back('{err: 0, cnt: 1, pulses: 1, disc: D, done_idx: 3 + 6 + D, sel: 3, spacing: 0});
        issue(3'd3);
        wait_done("after_reset", 200);
    endtask

    initial begin
        test_reset();
        test_switch();
        test_noop();
        test_range();
        test_retry();
        test_mismatch();
        test_expiry_ack();
        test_disconnect_reset();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
